// File: rtl/first_layer_tnnzeq_lanes.sv
// Sparse-ternary first layer: LANES features per cycle into per-neuron signed accumulators, sign-binarised on finish.
// Optional feature macro: TNN_BIAS_EN (accumulators start from per-neuron BIAS instead of zero).
module first_layer_tnnzeq_lanes #(
  parameter int FEAT_CNT   = 4,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 4,
  parameter int LANES      = 1,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] SPARSE_VALS = '0,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] MASK        = '0,
  parameter logic [HIDDEN_CNT*(FEAT_BITS+2+$clog2(FEAT_CNT+1))-1:0] BIAS = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic [HIDDEN_CNT-1:0]         out,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state
);

  localparam int ACC_BITS = FEAT_BITS + 2 + $clog2(FEAT_CNT + 1);
  localparam int GROUPS   = (FEAT_CNT + LANES - 1) / LANES;
  localparam int CNT_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PAD_BITS = ACC_BITS - FEAT_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [FEAT_CNT*FEAT_BITS-1:0] r_feat;
  logic [CNT_W-1:0]             r_cnt;
  logic [HIDDEN_CNT-1:0]        r_out;
  logic signed [ACC_BITS-1:0]   r_acc      [HIDDEN_CNT];
  logic signed [ACC_BITS-1:0]   w_acc_next [HIDDEN_CNT];
  logic signed [ACC_BITS-1:0]   w_acc_init [HIDDEN_CNT];
  logic                         w_accept;
  logic                         w_last_grp;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last_grp = (r_cnt == CNT_W'(GROUPS - 1));

  assign out       = r_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign dbg_state = r_state;

  always_comb begin
    for (int i = 0; i < HIDDEN_CNT; i++) begin
`ifdef TNN_BIAS_EN
      w_acc_init[i] = BIAS[i*ACC_BITS +: ACC_BITS];
`else
      w_acc_init[i] = '0;
`endif
    end
  end

  // Lanes past the last feature in a partial final group add nothing.
  always_comb begin
    int idx;
    logic [FEAT_BITS-1:0]       f;
    logic signed [ACC_BITS-1:0] fx;
    idx = 0;
    f   = '0;
    fx  = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) begin
      w_acc_next[i] = r_acc[i];
      for (int l = 0; l < LANES; l++) begin
        idx = int'(r_cnt) * LANES + l;
        if (idx < FEAT_CNT) begin
          if (MASK[i*FEAT_CNT+idx]) begin
            f  = r_feat[idx*FEAT_BITS +: FEAT_BITS];
            fx = signed'({{PAD_BITS{1'b0}}, f});
            if (SPARSE_VALS[i*FEAT_CNT+idx]) w_acc_next[i] = w_acc_next[i] + fx;
            else                             w_acc_next[i] = w_acc_next[i] - fx;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last_grp) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result is registered on the final RUN edge so it is already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      for (int i = 0; i < HIDDEN_CNT; i++) r_acc[i] <= '0;
    end else if (w_accept) begin
      r_feat <= features;
      r_cnt  <= '0;
      for (int i = 0; i < HIDDEN_CNT; i++) r_acc[i] <= w_acc_init[i];
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      for (int i = 0; i < HIDDEN_CNT; i++) r_acc[i] <= w_acc_next[i];
      if (w_last_grp) begin
        for (int i = 0; i < HIDDEN_CNT; i++) r_out[i] <= ~w_acc_next[i][ACC_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_first_layer_tnnzeq_lanes.sv
// Bench for first_layer_tnnzeq_lanes: LANES=1 and LANES=3 instances share stimulus and are checked every cycle
// against a latency/sum model, plus directed checks for latency, tie-to-one, back-to-back and mid-run reset.
module tb_first_layer_tnnzeq_lanes;

  localparam logic [7:0]  MASK_P = {4'b0101, 4'b1111};
  localparam logic [7:0]  SV_P   = {4'b0001, 4'b0011};
  localparam logic [17:0] BIAS_P = {9'h1FE, 9'h002};
`ifdef TNN_BIAS_EN
  localparam logic [1:0] EXP_T1 = 2'b01;
`else
  localparam logic [1:0] EXP_T1 = 2'b10;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] features;
  logic [1:0]  out_a, out_b, dbg_a, dbg_b;
  logic        busy_a, busy_b, done_a, done_b;

  int n_checks;
  int n_err;
  bit chk_en;

  first_layer_tnnzeq_lanes #(
    .FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(2), .LANES(1),
    .SPARSE_VALS(SV_P), .MASK(MASK_P), .BIAS(BIAS_P)
  ) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .features(features),
    .out(out_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
  );

  first_layer_tnnzeq_lanes #(
    .FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(2), .LANES(3),
    .SPARSE_VALS(SV_P), .MASK(MASK_P), .BIAS(BIAS_P)
  ) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .features(features),
    .out(out_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain ternary dot product per neuron, then sign.
  function automatic logic [1:0] ref_out(input logic [15:0] f);
    logic [7:0]  m;
    logic [7:0]  s;
    logic [17:0] b;
    logic [1:0]  r;
    int          sum;
    m = MASK_P;
    s = SV_P;
    b = BIAS_P;
    r = '0;
    for (int n = 0; n < 2; n++) begin
      sum = 0;
`ifdef TNN_BIAS_EN
      sum = (n == 0) ? 2 : -2;
`endif
      for (int j = 0; j < 4; j++) begin
        if (m[n*4+j]) sum += s[n*4+j] ? int'(f[j*4 +: 4]) : -int'(f[j*4 +: 4]);
      end
      r[n] = (sum >= 0);
    end
    if (b[0] === 1'bx) r = 'x;
    return r;
  endfunction

  // Model: per instance, busy cycles remaining (GROUPS+1 after accept), pending and visible result.
  int         m_left [2];
  logic [1:0] m_out  [2];
  logic [1:0] m_pend [2];
  int         m_grp  [2];

  initial begin
    m_grp[0] = 4;
    m_grp[1] = 2;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0;
      m_out[k]  = '0;
      m_pend[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] = 0;
        m_out[k]  = '0;
      end else if (m_left[k] == 0) begin
        if (start) begin
          m_pend[k] = ref_out(features);
          m_left[k] = m_grp[k] + 1;
        end
      end else begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 1) m_out[k] = m_pend[k];
      end
    end
  end

  // Scoreboard helper
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare, 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("out_l1",  out_a,           m_out[0]);
      check("busy_l1", {1'b0, busy_a},  {1'b0, m_left[0] > 0});
      check("done_l1", {1'b0, done_a},  {1'b0, m_left[0] == 1});
      check("out_l3",  out_b,           m_out[1]);
      check("busy_l3", {1'b0, busy_b},  {1'b0, m_left[1] > 0});
      check("done_l3", {1'b0, done_b},  {1'b0, m_left[1] == 1});
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {1'b0, busy_a || busy_b}, 2'b00);
  endtask

  task automatic run_measure(input logic [15:0] f, output int da, output int db, output int ba);
    da = 0;
    db = 0;
    ba = 0;
    @(negedge clk);
    features = f;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    features = 16'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (busy_a) ba++;
      if (done_a && da == 0) da = c;
      if (done_b && db == 0) db = c;
      @(negedge clk);
    end
  endtask

  initial begin
    int da, db, ba;
    int t_a [3];
    int t_b [3];
    int na, nb;
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    features = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_l1",  out_a, 2'b00);
    check("rst_busy_l1", {busy_a, done_a}, 2'b00);
    check("rst_out_l3",  out_b, 2'b00);
    check("rst_busy_l3", {busy_b, done_b}, 2'b00);
    rst = 1'b0;

    // f0..f3 = 3,5,2,7
    run_measure(16'h7253, da, db, ba);
    check("t1_done_cycle_l1", 2'(da), 2'(5));
    check("t1_done_cycle_l1_hi", 2'(da >> 2), 2'(5 >> 2));
    check("t2_done_cycle_l3", 2'(db), 2'(3));
    check("t1_busy_cycles", 2'(ba), 2'(5));
    check("t1_busy_cycles_hi", 2'(ba >> 2), 2'(5 >> 2));
    check("t1_out_l1", out_a, EXP_T1);
    check("t2_out_l3", out_b, EXP_T1);

`ifndef TNN_BIAS_EN
    run_measure(16'h0000, da, db, ba);
    check("t3_tie_l1", out_a, 2'b11);
    check("t3_tie_l3", out_b, 2'b11);
`endif

    // Start held high with features changing every cycle
    wait_idle();
    na = 0;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start    = 1'b1;
      features = 16'($urandom);
      if (done_a && na < 3) begin t_a[na] = c; na++; end
      if (done_b && nb < 3) begin t_b[nb] = c; nb++; end
    end
    start = 1'b0;
    check("t4_dones_l1", 2'(na), 2'(3));
    check("t4_dones_l3", 2'(nb), 2'(3));
    if (na == 3) check("t4_spacing_l1", 2'(t_a[2] - t_a[1]), 2'(6));
    if (na == 3) check("t4_spacing_l1b", 2'((t_a[2] - t_a[1]) >> 2), 2'(6 >> 2));
    if (nb == 3) check("t4_spacing_l3", 2'(t_b[2] - t_b[1]), 2'(4));
    if (nb == 3) check("t4_spacing_l3b", 2'((t_b[2] - t_b[1]) >> 2), 2'(4 >> 2));

    // Reset during RUN cycle 2 after a run that left out=EXP_T1
    wait_idle();
    run_measure(16'h7253, da, db, ba);
    @(negedge clk);
    features = 16'h7253;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_out_l1",  out_a, 2'b00);
    check("t5_busy_l1", {busy_a, done_a}, 2'b00);
    check("t5_busy_l3", {busy_b, done_b}, 2'b00);
    run_measure(16'h7253, da, db, ba);
    check("t5_redo_cycle", 2'(da), 2'(5));
    check("t5_redo_out", out_a, EXP_T1);

    // Randomised traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) != 0);
      features = 16'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
